arm_mc_ctrl: RTL

- Multicycle control unit for the ARM datapath. It replaces the single-cycle combinational decoder.
- The datapath shares one unified memory for instruction fetch and data access, through an address mux. It also has internal IR, ALUOut and Data registers.
- This block sequences each instruction over 3-5 states and owns the NZCV flag register. It gates every write enable on the condition-code check.
- Memory accesses use a ready handshake, so wait-stated memory is supported.

---
 rtl/arm_mc_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM control FSM: sequencing, NZCV flags, memory wait timeout.
// Optional perf counters (cycle_cnt, instr_cnt) under ARM_MC_PERF_EN.
module arm_mc_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic [1:0]  reg_src,
  output logic [3:0]  flags,
  output logic        fault,
  output logic [3:0]  state
`ifdef ARM_MC_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FAULT  = 4'd15
  } state_e;

  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);
  localparam logic [3:0] CMD_CMP = 4'b1010;

  state_e        state_q, state_d;
  logic [3:0]    flags_q, flags_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] wait_q, wait_d;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       cond_ok, cmd_ok, flags_ld;
  logic [1:0] dp_alu;
  logic       mem_st, tmo_hit;
  logic [CW-1:0] wait_inc;
  logic pc_w, rd_c, wr_c, ir_w, reg_w;

  assign cond = instr[31:28];
  assign op   = instr[27:26];
  assign cmd  = instr[24:21];

  always_comb begin
    case (cond)
      4'b0000: cond_ok = flags_q[2];
      4'b0001: cond_ok = ~flags_q[2];
      4'b1010: cond_ok = flags_q[3] == flags_q[0];
      4'b1011: cond_ok = flags_q[3] != flags_q[0];
      4'b1100: cond_ok = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ok = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    cmd_ok = 1'b1;
    dp_alu = 2'b00;
    case (cmd)
      4'b0100: dp_alu = 2'b00;
      4'b0010: dp_alu = 2'b01;
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      CMD_CMP: dp_alu = 2'b01;
      default: cmd_ok = 1'b0;
    endcase
  end

  assign mem_st = (state_q == S_FETCH) |
                  (state_q == S_MEMRD) |
                  (state_q == S_MEMWR);
  assign wait_inc = (wait_q == '1) ? wait_q : wait_q + CW'(1);
  assign tmo_hit = (MEM_TIMEOUT != 0) & (wait_inc == TMO);

  always_comb begin
    state_d     = state_q;
    flags_ld    = 1'b0;
    pc_w        = 1'b0;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    ir_w        = 1'b0;
    reg_w       = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 2'b00;
    imm_src     = 2'b00;
    reg_src     = 2'b00;
    case (state_q)
      S_FETCH: begin
        rd_c       = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_src[0] = (op == 2'b10);
        if (!cond_ok) state_d = S_FETCH;
        else begin
          case (op)
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            2'b00:   state_d = instr[25] ? S_EXECI : S_EXECR;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_b  = 2'b01;
        imm_src    = 2'b01;
        reg_src[1] = ~instr[20];
        state_d    = instr[20] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        rd_c    = 1'b1;
        if (mem_ready)    state_d = S_MEMWB;
        else if (tmo_hit) state_d = S_FAULT;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        wr_c    = 1'b1;
        reg_src = 2'b10;
        if (mem_ready)    state_d = S_FETCH;
        else if (tmo_hit) state_d = S_FAULT;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_control = dp_alu;
        if (cmd_ok) begin
          flags_ld = instr[20] | (cmd == CMD_CMP);
          state_d  = S_ALUWB;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_ALUWB: begin
        reg_w   = (cmd != CMD_CMP);
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        reg_src    = 2'b01;
        alu_src_b  = 2'b01;
        imm_src    = 2'b10;
        result_src = 2'b10;
        pc_w       = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  assign flags_d = flags_ld ? alu_flags : flags_q;
  assign fault_d = fault_q | (state_d == S_FAULT);

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)         wait_d = '0;
    else if (mem_st && !mem_ready)  wait_d = wait_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
      fault_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
    end
  end

  // Reset leaves state in FETCH, so requests must also be masked by rst.
  assign pc_write  = pc_w & ~rst;
  assign mem_read  = rd_c & ~rst;
  assign mem_write = wr_c & ~rst;
  assign ir_write  = ir_w & ~rst;
  assign reg_write = reg_w & ~rst;
  assign flags     = flags_q;
  assign fault     = fault_q;
  assign state     = state_q;

`ifdef ARM_MC_PERF_EN
  logic [31:0] cyc_q, ins_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= 32'd0;
      ins_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (state_d == S_FETCH && state_q != S_FETCH)
        ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`endif

endmodule
